btn_cmd_encoder: RTL and testbench

// - Front end of the calculator: turns four raw push-buttons into the one-hot command codes the ALU/7-seg block consumes on num_i.
// - Per button: 2-FF synchroniser + debounce; then a press FSM emits one registered single-cycle code per press.
// - A long-held clear button issues the global reset code 4'b1111.

---
 rtl/calc_pkg.sv | 33 +++
 rtl/btn_debounce.sv | 51 +++++
 rtl/btn_cmd_encoder.sv | 162 ++++++++++++++++
 tb/tb_btn_cmd_encoder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: one-hot command codes (also used by the
// ALU/7-seg block), button indices and the press-FSM state type.
package calc_pkg;

  localparam logic [3:0] CMD_NONE = 4'b0000;
  localparam logic [3:0] CMD_INC  = 4'b0001;
  localparam logic [3:0] CMD_DEC  = 4'b0010;
  localparam logic [3:0] CMD_NEXT = 4'b0100;
  localparam logic [3:0] CMD_CLR  = 4'b1000;
  localparam logic [3:0] CMD_RST  = 4'b1111;

  localparam int BTN_INC  = 0;
  localparam int BTN_DEC  = 1;
  localparam int BTN_NEXT = 2;
  localparam int BTN_CLR  = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HELD = 1'b1
  } btn_state_t;

  // Command for the highest-priority rising button: CLR > NEXT > DEC > INC.
  function automatic logic [3:0] prio_cmd(input logic [3:0] rise);
    logic [3:0] cmd;
    cmd = CMD_NONE;
    if (rise[BTN_CLR])       cmd = CMD_CLR;
    else if (rise[BTN_NEXT]) cmd = CMD_NEXT;
    else if (rise[BTN_DEC])  cmd = CMD_DEC;
    else if (rise[BTN_INC])  cmd = CMD_INC;
    return cmd;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw asynchronous button: 2-FF synchroniser followed by a counter
// debouncer. The level only changes after DEBOUNCE_CYCLES consecutive
// cycles of disagreement between the synchronised input and the level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count cycles of disagreement; flip the level on the last one.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser, level and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/btn_cmd_encoder.sv
// Calculator button front end: four debounced buttons -> one registered
// single-cycle one-hot command per press; a long clear hold emits CMD_RST.
// Optional feature macro: AUTO_REPEAT_EN (INC/DEC auto-repeat while held).
module btn_cmd_encoder
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int LONG_CYCLES     = 50000,
  parameter int REPEAT_DELAY    = 20000,
  parameter int REPEAT_PERIOD   = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_inc_i,
  input  logic       btn_dec_i,
  input  logic       btn_next_i,
  input  logic       btn_clr_i,
  output logic [3:0] num_o,
  output logic       cmd_valid_o,
  output logic [3:0] btn_level_o
);

  // Reject nonsensical timing parameters at elaboration.
  if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("btn_cmd_encoder: all cycle parameters must be >= 1");
  end

  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  logic [3:0] raw;
  logic [3:0] lvl;
  logic [3:0] rise;

  assign raw = {btn_clr_i, btn_next_i, btn_dec_i, btn_inc_i};

  for (genvar i = 0; i < 4; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (raw[i]),
      .level_o(lvl[i])
    );
  end

  btn_state_t    state_q, state_d;
  logic [3:0]    held_q, held_d;
  logic [3:0]    lvl_prev_q, lvl_prev_d;
  logic [3:0]    num_q, num_d;
  logic          valid_q, valid_d;
  logic [HW-1:0] hold_q, hold_d;

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RPT_DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rpt_q, rpt_d;
  logic          rpt_first_q, rpt_first_d;
  logic          rpt_btn_high;

  assign rpt_btn_high = (held_q == CMD_INC && lvl[BTN_INC]) ||
                        (held_q == CMD_DEC && lvl[BTN_DEC]);
`endif

  assign rise = lvl & ~lvl_prev_q;

  // Press FSM: accept one press in IDLE, then track hold/repeat in HELD.
  always_comb begin
    state_d    = state_q;
    held_d     = held_q;
    lvl_prev_d = lvl;
    num_d      = CMD_NONE;
    hold_d     = hold_q;
`ifdef AUTO_REPEAT_EN
    rpt_d       = rpt_q;
    rpt_first_d = rpt_first_q;
`endif
    case (state_q)
      IDLE: begin
        if (|rise) begin
          num_d   = prio_cmd(rise);
          held_d  = prio_cmd(rise);
          state_d = HELD;
          hold_d  = '0;
`ifdef AUTO_REPEAT_EN
          rpt_d       = '0;
          rpt_first_d = 1'b1;
`endif
        end
      end
      default: begin
        if (lvl == 4'b0000) begin
          state_d = IDLE;
          held_d  = CMD_NONE;
        end else begin
          // Clearing held_cmd on release stops any later RST/repeat for this press.
          if (held_q == CMD_CLR) begin
            if (!lvl[BTN_CLR]) begin
              held_d = CMD_NONE;
            end else if (hold_q != HOLD_MAX) begin
              hold_d = hold_q + 1'b1;
              if (hold_q == HOLD_LAST) num_d = CMD_RST;
            end
          end
`ifdef AUTO_REPEAT_EN
          if (held_q == CMD_INC || held_q == CMD_DEC) begin
            if (rpt_btn_high) begin
              if (rpt_q == (rpt_first_q ? RPT_DELAY_LAST : RPT_PERIOD_LAST)) begin
                num_d       = held_q;
                rpt_d       = '0;
                rpt_first_d = 1'b0;
              end else begin
                rpt_d = rpt_q + 1'b1;
              end
            end else begin
              held_d = CMD_NONE;
            end
          end
`endif
        end
      end
    endcase
    valid_d = (num_d != CMD_NONE);
  end

  // FSM, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      held_q     <= CMD_NONE;
      lvl_prev_q <= 4'b0000;
      num_q      <= CMD_NONE;
      valid_q    <= 1'b0;
      hold_q     <= '0;
`ifdef AUTO_REPEAT_EN
      rpt_q       <= '0;
      rpt_first_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      held_q     <= held_d;
      lvl_prev_q <= lvl_prev_d;
      num_q      <= num_d;
      valid_q    <= valid_d;
      hold_q     <= hold_d;
`ifdef AUTO_REPEAT_EN
      rpt_q       <= rpt_d;
      rpt_first_q <= rpt_first_d;
`endif
    end
  end

  assign num_o       = num_q;
  assign cmd_valid_o = valid_q;
  assign btn_level_o = lvl;

endmodule

// File: tb/tb_btn_cmd_encoder.sv
// Directed bench for btn_cmd_encoder with short timing parameters
// (debounce 4, long-hold 20, repeat delay 10, repeat period 5).
module tb_btn_cmd_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_inc, btn_dec, btn_next, btn_clr;
  logic [3:0] num;
  logic       vld;
  logic [3:0] lvl;

  int checks   = 0;
  int failures = 0;

  btn_cmd_encoder #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_inc_i  (btn_inc),
    .btn_dec_i  (btn_dec),
    .btn_next_i (btn_next),
    .btn_clr_i  (btn_clr),
    .num_o      (num),
    .cmd_valid_o(vld),
    .btn_level_o(lvl)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_inc = 0; btn_dec = 0; btn_next = 0; btn_clr = 0;
    for (int k = 0; k < 3; k++) step();
    checks++; if (num !== 4'b0000) begin failures++; $display("FAIL reset_num got=%b want=0000", num); end
    checks++; if (vld !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", vld); end
    checks++; if (lvl !== 4'b0000) begin failures++; $display("FAIL reset_level got=%b want=0000", lvl); end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) step();
  endtask

  task automatic test_single_press();
    logic [3:0] exp_num;
    btn_inc = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_num = (k == 7) ? 4'b0001 : 4'b0000;
      checks++; if (num !== exp_num) begin failures++; $display("FAIL single_num k=%0d got=%b want=%b", k, num, exp_num); end
      checks++; if (vld !== (k == 7)) begin failures++; $display("FAIL single_valid k=%0d got=%b want=%b", k, vld, (k == 7)); end
      if (k >= 6) begin
        checks++; if (lvl !== 4'b0001) begin failures++; $display("FAIL single_level k=%0d got=%b want=0001", k, lvl); end
      end
    end
    btn_inc = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++; if (num !== 4'b0000) begin failures++; $display("FAIL single_release_num k=%0d got=%b want=0000", k, num); end
    end
    checks++; if (lvl !== 4'b0000) begin failures++; $display("FAIL single_release_level got=%b want=0000", lvl); end
  endtask

  task automatic test_glitch();
    btn_dec = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 3) btn_dec = 1'b0;
      checks++; if (num !== 4'b0000) begin failures++; $display("FAIL glitch_num k=%0d got=%b want=0000", k, num); end
      checks++; if (lvl !== 4'b0000) begin failures++; $display("FAIL glitch_level k=%0d got=%b want=0000", k, lvl); end
    end
  endtask

  task automatic test_priority();
    logic [3:0] exp_num;
    btn_inc = 1'b1; btn_next = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp_num = (k == 7) ? 4'b0100 : 4'b0000;
      checks++; if (num !== exp_num) begin failures++; $display("FAIL prio_num k=%0d got=%b want=%b", k, num, exp_num); end
    end
    checks++; if (lvl !== 4'b0101) begin failures++; $display("FAIL prio_level got=%b want=0101", lvl); end
    btn_next = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++; if (num !== 4'b0000) begin failures++; $display("FAIL prio_next_release k=%0d got=%b want=0000", k, num); end
    end
    btn_inc = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++; if (num !== 4'b0000) begin failures++; $display("FAIL prio_inc_release k=%0d got=%b want=0000", k, num); end
    end
    btn_inc = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp_num = (k == 7) ? 4'b0001 : 4'b0000;
      checks++; if (num !== exp_num) begin failures++; $display("FAIL prio_repress k=%0d got=%b want=%b", k, num, exp_num); end
    end
    btn_inc = 1'b0;
    for (int k = 0; k < 12; k++) step();
  endtask

  task automatic test_clr_long();
    logic [3:0] exp_num;
    btn_clr = 1'b1;
    for (int k = 1; k <= 55; k++) begin
      step();
      if (k == 40) btn_clr = 1'b0;
      exp_num = (k == 7) ? 4'b1000 : (k == 27) ? 4'b1111 : 4'b0000;
      checks++; if (num !== exp_num) begin failures++; $display("FAIL clr_long_num k=%0d got=%b want=%b", k, num, exp_num); end
      checks++; if (vld !== (exp_num != 4'b0000)) begin failures++; $display("FAIL clr_long_valid k=%0d got=%b want=%b", k, vld, (exp_num != 4'b0000)); end
    end
  endtask

  task automatic test_auto_repeat();
    logic [3:0] exp_num;
    logic       rep;
    btn_inc = 1'b1;
    for (int k = 1; k <= 55; k++) begin
      step();
      if (k == 40) btn_inc = 1'b0;
`ifdef AUTO_REPEAT_EN
      rep = (k >= 17) && (k <= 42) && (((k - 17) % 5) == 0);
`else
      rep = 1'b0;
`endif
      exp_num = (k == 7 || rep) ? 4'b0001 : 4'b0000;
      checks++; if (num !== exp_num) begin failures++; $display("FAIL repeat_num k=%0d got=%b want=%b", k, num, exp_num); end
    end
  endtask

  task automatic test_rst_mid();
    logic [3:0] exp_num;
    btn_clr = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      exp_num = (k == 7) ? 4'b1000 : 4'b0000;
      checks++; if (num !== exp_num) begin failures++; $display("FAIL rst_mid_pre k=%0d got=%b want=%b", k, num, exp_num); end
    end
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++; if (num !== 4'b0000) begin failures++; $display("FAIL rst_mid_num k=%0d got=%b want=0000", k, num); end
      checks++; if (vld !== 1'b0) begin failures++; $display("FAIL rst_mid_valid k=%0d got=%b want=0", k, vld); end
      checks++; if (lvl !== 4'b0000) begin failures++; $display("FAIL rst_mid_level k=%0d got=%b want=0000", k, lvl); end
    end
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp_num = (k == 7) ? 4'b1000 : 4'b0000;
      checks++; if (num !== exp_num) begin failures++; $display("FAIL rst_mid_post k=%0d got=%b want=%b", k, num, exp_num); end
    end
    btn_clr = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      step();
      checks++; if (num !== 4'b0000) begin failures++; $display("FAIL rst_mid_release k=%0d got=%b want=0000", k, num); end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_priority();
    test_clr_long();
    test_auto_repeat();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
